fpu_fmul_wb: RTL and testbench



---
 rtl/fpu_fmul_wb.sv | 147 ++++++++++++++
 tb/tb_fpu_fmul_wb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fmul_wb.sv
// fpu_fmul_wb: post-multiply fix-up and writeback buffer for the double-precision FMUL path.
// The S1 register holds one accepted product and its operands. S1 patches the IEEE special
// cases the datapath ignores: NaN, infinity, zero/denormal operands and the underflow sign.
// It then pushes the result and flags {invalid, overflow, underflow, zero} into a 2-entry FIFO
// that feeds the FPR writeback port.

module fpu_fmul_wb (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_srca,
  input  logic [63:0] in_srcb,
  input  logic [63:0] in_prod,
  input  logic [3:0]  in_rn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_rn,
  output logic [3:0]  out_flags
);

  logic        s1Valid_q, s1Valid_d;
  logic [1:0]  count_q, count_d;
  logic        rdPtr_q, rdPtr_d;
  logic        wrPtr_q, wrPtr_d;

  logic [63:0] srcA_q, srcB_q, prod_q;
  logic [3:0]  rn_q;
  logic        aNan_q, aInf_q, aZero_q;
  logic        bNan_q, bInf_q, bZero_q;

  logic [63:0] fifoData_q  [2];
  logic [3:0]  fifoRn_q    [2];
  logic [3:0]  fifoFlags_q [2];

  logic        accept, s1Adv, pop;
  logic        resSign;
  logic [63:0] fixData;
  logic [3:0]  fixFlags;

  // Handshake and next-state for S1 occupancy, FIFO pointers and count; in_ready never looks at out_ready
  always_comb begin
    in_ready  = !s1Valid_q | (count_q < 2'd2);
    accept    = in_valid & in_ready;
    s1Adv     = s1Valid_q & (count_q < 2'd2);
    pop       = out_valid & out_ready;
    s1Valid_d = s1Valid_q;
    if (accept)
      s1Valid_d = 1'b1;
    else if (s1Adv)
      s1Valid_d = 1'b0;
    count_d = count_q + {1'b0, s1Adv} - {1'b0, pop};
    wrPtr_d = s1Adv ? ~wrPtr_q : wrPtr_q;
    rdPtr_d = pop ? ~rdPtr_q : rdPtr_q;
  end

  // Control state: reset beats flush, and both discard any same-cycle accept or pop
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      s1Valid_q <= 1'b0;
      count_q   <= 2'd0;
      rdPtr_q   <= 1'b0;
      wrPtr_q   <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      count_q   <= count_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
    end
  end

  // S1 capture: operands, raw product, destination and per-operand class (denormals count as zero)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      srcA_q  <= 64'd0;
      srcB_q  <= 64'd0;
      prod_q  <= 64'd0;
      rn_q    <= 4'd0;
      aNan_q  <= 1'b0;
      aInf_q  <= 1'b0;
      aZero_q <= 1'b0;
      bNan_q  <= 1'b0;
      bInf_q  <= 1'b0;
      bZero_q <= 1'b0;
    end else if (accept && !flush) begin
      srcA_q  <= in_srca;
      srcB_q  <= in_srcb;
      prod_q  <= in_prod;
      rn_q    <= in_rn;
      aNan_q  <= (in_srca[62:52] == 11'h7FF) && (in_srca[51:0] != 52'd0);
      aInf_q  <= (in_srca[62:52] == 11'h7FF) && (in_srca[51:0] == 52'd0);
      aZero_q <= (in_srca[62:52] == 11'h000);
      bNan_q  <= (in_srcb[62:52] == 11'h7FF) && (in_srcb[51:0] != 52'd0);
      bInf_q  <= (in_srcb[62:52] == 11'h7FF) && (in_srcb[51:0] == 52'd0);
      bZero_q <= (in_srcb[62:52] == 11'h000);
    end
  end

  // Special-case fix-up on the S1 contents, first matching rule wins
  always_comb begin
    resSign  = srcA_q[63] ^ srcB_q[63];
    fixData  = prod_q;
    fixFlags = 4'b0000;
    if (aNan_q) begin
      fixData = srcA_q | 64'h0008_0000_0000_0000;
    end else if (bNan_q) begin
      fixData = srcB_q | 64'h0008_0000_0000_0000;
    end else if ((aInf_q && bZero_q) || (aZero_q && bInf_q)) begin
      fixData  = 64'h7FF8_0000_0000_0000;
      fixFlags = 4'b1000;
    end else if (aInf_q || bInf_q) begin
      fixData = {resSign, 11'h7FF, 52'd0};
    end else if (aZero_q || bZero_q) begin
      fixData  = {resSign, 63'd0};
      fixFlags = 4'b0001;
    end else if (prod_q[62:52] == 11'h7FF) begin
      fixData  = {resSign, 11'h7FF, 52'd0};
      fixFlags = 4'b0100;
    end else if (prod_q[62:0] == 63'd0) begin
      fixData  = {resSign, 63'd0};
      fixFlags = 4'b0011;
    end
  end

  // FIFO storage: written at wrPtr when S1 advances; cleared on reset so outputs read zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        fifoData_q[i]  <= 64'd0;
        fifoRn_q[i]    <= 4'd0;
        fifoFlags_q[i] <= 4'd0;
      end
    end else if (s1Adv && !flush) begin
      fifoData_q[wrPtr_q]  <= fixData;
      fifoRn_q[wrPtr_q]    <= rn_q;
      fifoFlags_q[wrPtr_q] <= fixFlags;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifoData_q[rdPtr_q];
  assign out_rn    = fifoRn_q[rdPtr_q];
  assign out_flags = fifoFlags_q[rdPtr_q];

endmodule

// File: tb/tb_fpu_fmul_wb.sv
// tb_fpu_fmul_wb: directed vectors for the FMUL fix-up/writeback buffer plus hand-written
// sequences for backpressure, flush and reset with a full pipe.

module tb_fpu_fmul_wb;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_srca;
  logic [63:0] in_srcb;
  logic [63:0] in_prod;
  logic [3:0]  in_rn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_rn;
  logic [3:0]  out_flags;

  int checks;
  int failures;

  typedef struct {
    logic [63:0] srca;
    logic [63:0] srcb;
    logic [63:0] prod;
    logic [3:0]  rn;
    logic [63:0] expData;
    logic [3:0]  expFlags;
  } vec_t;

  vec_t vecs[12];

  fpu_fmul_wb dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_srca   (in_srca),
    .in_srcb   (in_srcb),
    .in_prod   (in_prod),
    .in_rn     (in_rn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rn    (out_rn),
    .out_flags (out_flags)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge, where outputs are sampled and inputs changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic presentItem(input logic [3:0] rn);
    in_valid = 1'b1;
    in_srca  = 64'h3FF0_0000_0000_0000;
    in_srcb  = 64'h3FF0_0000_0000_0000;
    in_prod  = {12'h3FF, 48'd0, rn};
    in_rn    = rn;
  endtask

  // Push one vector through with out_ready high and check exact latency and contents
  task automatic applyStimulus(input int idx);
    in_valid  = 1'b1;
    in_srca   = vecs[idx].srca;
    in_srcb   = vecs[idx].srcb;
    in_prod   = vecs[idx].prod;
    in_rn     = vecs[idx].rn;
    out_ready = 1'b1;
    checkOutput($sformatf("vec%0d_in_ready", idx), {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    checkOutput($sformatf("vec%0d_valid_s1", idx), {63'd0, out_valid}, 64'd0);
    tick();
    checkOutput($sformatf("vec%0d_valid", idx), {63'd0, out_valid}, 64'd1);
    checkOutput($sformatf("vec%0d_data", idx), out_data, vecs[idx].expData);
    checkOutput($sformatf("vec%0d_rn", idx), {60'd0, out_rn}, {60'd0, vecs[idx].rn});
    checkOutput($sformatf("vec%0d_flags", idx), {60'd0, out_flags}, {60'd0, vecs[idx].expFlags});
    tick();
    checkOutput($sformatf("vec%0d_drained", idx), {63'd0, out_valid}, 64'd0);
  endtask

  // Fill FIFO (2) and S1 (1) with out_ready low; in_ready must drop after the third accept
  task automatic fillThree(input string tag);
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      presentItem(4'(i));
      checkOutput($sformatf("%s_ready%0d", tag, i), {63'd0, in_ready}, 64'd1);
      tick();
    end
    in_valid = 1'b0;
    checkOutput($sformatf("%s_ready_low", tag), {63'd0, in_ready}, 64'd0);
    checkOutput($sformatf("%s_out_valid", tag), {63'd0, out_valid}, 64'd1);
    checkOutput($sformatf("%s_head_rn", tag), {60'd0, out_rn}, 64'd1);
  endtask

  // Main sequence: reset, vector table, backpressure, flush, reset mid-stream
  initial begin
    int sent;
    int cycles;
    logic acc;
    logic [3:0] got[$];

    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_srca   = 64'd0;
    in_srcb   = 64'd0;
    in_prod   = 64'd0;
    in_rn     = 4'd0;
    out_ready = 1'b1;

    vecs[0]  = '{64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd3, 64'h4008_0000_0000_0000, 4'b0000};
    vecs[1]  = '{64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h1234_0000_0000_0000, 4'd1, 64'h7FF8_0000_0000_0000, 4'b1000};
    vecs[2]  = '{64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd2, 64'h7FF8_0000_0000_0001, 4'b0000};
    vecs[3]  = '{64'hBFF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 4'd4, 64'hFFF0_0000_0000_0000, 4'b0000};
    vecs[4]  = '{64'h8010_0000_0000_0000, 64'h0010_0000_0000_0000, 64'h0000_0000_0000_0000, 4'd5, 64'h8000_0000_0000_0000, 4'b0011};
    vecs[5]  = '{64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0002, 64'h4000_0000_0000_0000, 4'd6, 64'hFFF8_0000_0000_0002, 4'b0000};
    vecs[6]  = '{64'h8000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h0000_0000_0000_0000, 4'd7, 64'h7FF8_0000_0000_0000, 4'b1000};
    vecs[7]  = '{64'h0000_0000_0000_0001, 64'hC000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd8, 64'h8000_0000_0000_0000, 4'b0001};
    vecs[8]  = '{64'h7FE0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_1234, 4'd9, 64'h7FF0_0000_0000_0000, 4'b0100};
    vecs[9]  = '{64'h7FF0_0000_0000_0005, 64'h7FF8_0000_0000_0009, 64'h0000_0000_0000_0000, 4'd10, 64'h7FF8_0000_0000_0005, 4'b0000};
    vecs[10] = '{64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'hC018_0000_0000_0000, 4'd11, 64'hC018_0000_0000_0000, 4'b0000};
    vecs[11] = '{64'hFFE0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 4'd15, 64'hFFF0_0000_0000_0000, 4'b0100};

    tick();
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_rn", {60'd0, out_rn}, 64'd0);
    checkOutput("rst_out_flags", {60'd0, out_flags}, 64'd0);

    for (int i = 0; i < 12; i++)
      applyStimulus(i);

    $display("[TB] backpressure sequence");
    fillThree("bp");
    presentItem(4'd4);
    tick();
    tick();
    checkOutput("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_hold_rn", {60'd0, out_rn}, 64'd1);
    checkOutput("bp_hold_data", out_data, 64'h3FF0_0000_0000_0001);
    out_ready = 1'b1;
    sent   = 3;
    cycles = 0;
    while (got.size() < 5 && cycles < 40) begin
      if (out_valid)
        got.push_back(out_rn);
      acc = in_valid & in_ready;
      tick();
      cycles++;
      if (acc) begin
        sent++;
        if (sent == 5)
          in_valid = 1'b0;
        else
          presentItem(4'(sent + 1));
      end
    end
    checkOutput("bp_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size())
        checkOutput($sformatf("bp_order%0d", i), {60'd0, got[i]}, 64'(i + 1));
    end
    checkOutput("bp_no_gaps", {63'd0, cycles <= 6}, 64'd1);
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("bp_no_dup", {63'd0, out_valid}, 64'd0);

    $display("[TB] flush with full pipe");
    fillThree("fl");
    presentItem(4'd9);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("fl_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    tick();
    checkOutput("fl_no_ghost", {63'd0, out_valid}, 64'd0);
    applyStimulus(0);

    $display("[TB] reset with full pipe");
    fillThree("rs");
    presentItem(4'd9);
    resetn = 1'b0;
    flush  = 1'b1;
    tick();
    resetn   = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("rs_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rs_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rs_out_data", out_data, 64'd0);
    checkOutput("rs_out_rn", {60'd0, out_rn}, 64'd0);
    checkOutput("rs_out_flags", {60'd0, out_flags}, 64'd0);
    tick();
    checkOutput("rs_no_ghost", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
